// File: rtl/div_repeated_sub_if.sv
// ============================================================================
//  Module      : div_repeated_sub_if
//  Description : Operand/result bundle for the repeated-subtraction divider.
//                The abort line is present only when DIV_ABORT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_repeated_sub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] data_in;
`ifdef DIV_ABORT_EN
    logic             abort;
`endif
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             err;

    // Requester side: issues operands, observes results
    modport master (
        output start,
        output data_in,
`ifdef DIV_ABORT_EN
        output abort,
`endif
        input  quotient,
        input  remainder,
        input  busy,
        input  done,
        input  err
    );

    // Divider side
    modport slave (
        input  start,
        input  data_in,
`ifdef DIV_ABORT_EN
        input  abort,
`endif
        output quotient,
        output remainder,
        output busy,
        output done,
        output err
    );
endinterface

`default_nettype wire

// File: rtl/div_repeated_sub.sv
// ============================================================================
//  Module      : div_repeated_sub
//  Description : Unsigned divider by repeated subtraction. Dividend and
//                divisor arrive on a shared bus on consecutive edges; the
//                quotient counts the subtractions performed.
//                Optional feature macro: DIV_ABORT_EN (adds abort input).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_repeated_sub #(
    parameter int WIDTH = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    div_repeated_sub_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LDB  = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] C_ONES = {WIDTH{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] w_dvs_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= C_ZERO;
            r_quo   <= C_ZERO;
            r_dvs   <= C_ZERO;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_dvs   <= w_dvs_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state and datapath update selection
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_quo_nxt   = r_quo;
        w_dvs_nxt   = r_dvs;
        w_err_nxt   = r_err;
        w_ge        = (r_rem >= r_dvs);
        w_diff      = r_rem - r_dvs;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_rem_nxt   = bus.data_in;
                    w_quo_nxt   = C_ZERO;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_LDB;
                end
            end
            S_LDB: begin
                // A zero divisor finishes at once with an all-ones quotient
                if (bus.data_in == C_ZERO) begin
                    w_err_nxt   = 1'b1;
                    w_quo_nxt   = C_ONES;
                    w_state_nxt = S_DONE;
                end else begin
                    w_dvs_nxt   = bus.data_in;
                    w_state_nxt = S_SUB;
                end
            end
            S_SUB: begin
                // Subtract only when it cannot underflow
                if (w_ge) begin
                    w_rem_nxt = w_diff;
                    w_quo_nxt = r_quo + C_ONE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

`ifdef DIV_ABORT_EN
        // Abort overrides every LDB/SUB decision and leaves no result behind
        if (((r_state == S_LDB) || (r_state == S_SUB)) && bus.abort) begin
            w_state_nxt = S_IDLE;
            w_quo_nxt   = C_ZERO;
            w_rem_nxt   = C_ZERO;
            w_err_nxt   = 1'b0;
        end
`endif
    end

    assign bus.quotient  = r_quo;
    assign bus.remainder = r_rem;
    assign bus.err       = r_err;
    assign bus.busy      = (r_state == S_LDB) || (r_state == S_SUB);
    assign bus.done      = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_div_repeated_sub.sv
// ============================================================================
//  Module      : tb_div_repeated_sub
//  Description : Scoreboard bench for div_repeated_sub with directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_repeated_sub;

    localparam int WIDTH = 16;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             err;
        int               done_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_miss;
    exp_t sb[$];
    logic prev_done;

    div_repeated_sub_if #(.WIDTH(WIDTH)) bus ();

    div_repeated_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising done pops one expected result
    always @(negedge clk) begin
        if (bus.done && !prev_done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_miss++;
                $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient",  32'(bus.quotient),  32'(e.q));
                check("remainder", 32'(bus.remainder), 32'(e.r));
                check("err",       32'(bus.err),       32'(e.err));
                check("done_edge", 32'(cyc),           32'(e.done_cyc));
            end
        end
        prev_done = bus.done;
    end

    // One division: dividend a, divisor b, expected results and done latency
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input logic ee, input int lat, input bit poke);
        exp_t e;
        bit   busy_ok;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = a;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.data_in = b;
        e.q = eq; e.r = er; e.err = ee; e.done_cyc = cyc + lat;
        sb.push_back(e);
        check("done_drop", 32'(bus.done), 32'd0);
        check("busy_ldb",  32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        bus.data_in = 16'hBEEF;
        if (poke) begin
            // Stray start and operand while busy must be ignored
            @(negedge clk);
            bus.start   = 1'b1;
            bus.data_in = 16'h0003;
            @(posedge clk);
            #1;
            bus.start   = 1'b0;
            bus.data_in = 16'hBEEF;
        end
        busy_ok = 1'b1;
        for (int k = 0; k < 70000; k++) begin
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check("done_timeout", 32'(bus.done), 32'd1);
        check("busy_while_running", 32'(busy_ok), 32'd1);
        check("busy_in_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bit quiet;
        cyc         = 0;
        n_cmp       = 0;
        n_miss      = 0;
        prev_done   = 1'b0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.data_in = '0;
`ifdef DIV_ABORT_EN
        bus.abort   = 1'b0;
`endif
        #1;
        check("rst_quotient",  32'(bus.quotient),  32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_done",      32'(bus.done),      32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(16'd100,   16'd7, 16'd14,    16'd2,  1'b0, 16,    1'b1);
        run_op(16'd5,     16'd9, 16'd0,     16'd5,  1'b0, 2,     1'b0);
        run_op(16'd42,    16'd0, 16'hFFFF,  16'd42, 1'b1, 1,     1'b0);
        run_op(16'd20,    16'd4, 16'd5,     16'd0,  1'b0, 7,     1'b0);
        run_op(16'hFFFF,  16'd1, 16'hFFFF,  16'd0,  1'b0, 65537, 1'b0);

        // Asynchronous reset in the middle of 1000/3
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 16'd1000;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.data_in = 16'd3;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_quotient",  32'(bus.quotient),  32'd0);
        check("mid_rst_remainder", 32'(bus.remainder), 32'd0);
        check("mid_rst_busy",      32'(bus.busy),      32'd0);
        check("mid_rst_done",      32'(bus.done),      32'd0);
        check("mid_rst_err",       32'(bus.err),       32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 5, 1'b0);

`ifdef DIV_ABORT_EN
        // Abort in SUB: back to IDLE with cleared results, no done
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 16'd50;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.data_in = 16'd5;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_busy",      32'(bus.busy),      32'd0);
        check("abort_done",      32'(bus.done),      32'd0);
        check("abort_quotient",  32'(bus.quotient),  32'd0);
        check("abort_remainder", 32'(bus.remainder), 32'd0);
        check("abort_err",       32'(bus.err),       32'd0);
        quiet = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.done) quiet = 1'b0;
        end
        check("abort_no_done", 32'(quiet), 32'd1);
`else
        quiet = 1'b1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
